// File: rtl/abro_stimulus_driver.sv
// Initiating end of the ABRO handshake: pulses a/b at programmed delays, then
// waits a bounded number of cycles for o and reports pass/fail.
module abro_stimulus_driver #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_delay_a,
  input  logic [CNT_W-1:0] cmd_delay_b,
  output logic             a,
  output logic             b,
  input  logic             o,
  output logic             done,
  output logic             pass,
  output logic [1:0]       state
);

  localparam int unsigned     TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] da_q, db_q, run_cnt, run_last;
  logic [TO_W-1:0]  to_cnt;
  logic             fired_a, fired_b, pass_q;

  // RUN ends at the larger delay, so the counter never has to wrap.
  assign run_last = (da_q > db_q) ? da_q : db_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (cmd_valid) state_d = S_RUN;
      S_RUN: begin
        if (o)                         state_d = S_DONE;
        else if (run_cnt == run_last)  state_d = S_WAIT;
      end
      S_WAIT: if (o || to_cnt == TO_LAST) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    a         = (state_q == S_RUN) && !fired_a && (run_cnt == da_q);
    b         = (state_q == S_RUN) && !fired_b && (run_cnt == db_q);
    done      = (state_q == S_DONE);
    pass      = pass_q;
    state     = state_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      da_q    <= '0;
      db_q    <= '0;
      run_cnt <= '0;
      to_cnt  <= '0;
      fired_a <= 1'b0;
      fired_b <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            da_q    <= cmd_delay_a;
            db_q    <= cmd_delay_b;
            run_cnt <= '0;
            fired_a <= 1'b0;
            fired_b <= 1'b0;
            pass_q  <= 1'b0;
          end
        end
        S_RUN: begin
          if (a) fired_a <= 1'b1;
          if (b) fired_b <= 1'b1;
          if (!o && run_cnt != run_last) run_cnt <= run_cnt + CNT_W'(1);
          to_cnt <= '0;
        end
        S_WAIT: begin
          if (o)                      pass_q <= 1'b1;
          else if (to_cnt != TO_LAST) to_cnt <= to_cnt + TO_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
